// File: rtl/imm_extender_pipe.sv
// Pipelined RISC-V immediate extractor/extender with a two-entry skid buffer.
// One cycle latency, full throughput under back-pressure, tag and error sideband.
module imm_extender_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [3:0]       in_control,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  logic             w_s;
  logic [63:0]      w_full;
  logic [XLEN-1:0]  w_imm;
  logic             w_err;
  logic             w_acc;
  logic             w_xfer;
  logic             w_unused;

  logic [XLEN-1:0]  r_out_imm;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_err;
  logic             r_out_vld;
  logic [XLEN-1:0]  r_sk_imm;
  logic [TAG_W-1:0] r_sk_tag;
  logic             r_sk_err;
  logic             r_sk_vld;

  assign w_s = in_instr[31];

  // Build a 64-bit result and narrow it; the RV32 view is the low half.
  always_comb begin
    w_full = '0;
    w_err  = 1'b0;
    case (in_control)
      4'b0000: w_full = {{52{w_s}}, in_instr[31:20]};
      4'b0001: w_full = {{52{w_s}}, in_instr[31:25], in_instr[11:7]};
      4'b0010: w_full = {{51{w_s}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
      4'b0011: w_full = {{43{w_s}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
      4'b0100: w_full = {{32{w_s}}, in_instr[31:12], 12'b0};
      4'b0101: w_full = {52'b0, in_instr[31:20]};
      4'b0110: w_full = (XLEN == 64) ? {58'b0, in_instr[25:20]}
                                     : {59'b0, in_instr[24:20]};
      4'b0111: w_full = {59'b0, in_instr[19:15]};
      default: begin
        w_full = '0;
        w_err  = 1'b1;
      end
    endcase
  end

  assign w_imm    = w_full[XLEN-1:0];
  assign w_unused = ^{in_instr[6:0], w_full};

  assign in_ready  = !r_sk_vld;
  assign out_valid = r_out_vld;
  assign out_imm   = r_out_imm;
  assign out_tag   = r_out_tag;
  assign out_err   = r_out_err;

  assign w_acc  = in_valid && !r_sk_vld;
  assign w_xfer = r_out_vld && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_out_imm <= '0;
      r_out_tag <= '0;
      r_out_err <= 1'b0;
      r_out_vld <= 1'b0;
      r_sk_imm  <= '0;
      r_sk_tag  <= '0;
      r_sk_err  <= 1'b0;
      r_sk_vld  <= 1'b0;
    end else if (r_sk_vld) begin
      if (w_xfer) begin
        r_out_imm <= r_sk_imm;
        r_out_tag <= r_sk_tag;
        r_out_err <= r_sk_err;
        r_sk_vld  <= 1'b0;
      end
    end else if (w_acc) begin
      if (!r_out_vld || w_xfer) begin
        r_out_imm <= w_imm;
        r_out_tag <= in_tag;
        r_out_err <= w_err;
        r_out_vld <= 1'b1;
      end else begin
        r_sk_imm  <= w_imm;
        r_sk_tag  <= in_tag;
        r_sk_err  <= w_err;
        r_sk_vld  <= 1'b1;
      end
    end else if (w_xfer) begin
      r_out_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_extender_pipe.sv
// Self-checking bench: RV32 and RV64 instances share stimulus and are
// checked against an occupancy/order scoreboard and an arithmetic model.
module tb_imm_extender_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [3:0]  in_control, in_tag;

  logic        r32, v32, e32, r64, v64, e64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [3:0]  t32, t64;

  always #5 clk = ~clk;

  imm_extender_pipe #(.XLEN(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r32),
    .in_instr(in_instr), .in_control(in_control), .in_tag(in_tag),
    .out_valid(v32), .out_ready(out_ready),
    .out_imm(imm32), .out_tag(t32), .out_err(e32));

  imm_extender_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r64),
    .in_instr(in_instr), .in_control(in_control), .in_tag(in_tag),
    .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_tag(t64), .out_err(e64));

  typedef struct {
    logic [31:0] x32;
    logic [63:0] x64;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] ins;
    logic [31:0] x32;
    logic [63:0] x64;
    logic        err;
  } vec_t;

  exp_t q[$];
  exp_t cur;
  bit   zexp;
  int   nerr = 0;
  int   nchk = 0;

  // Immediate computed with signed shifts and weights rather than bit slicing.
  function automatic logic [63:0] model(input logic [31:0] w,
                                        input logic [3:0] c,
                                        input bit x64);
    longint s, u, v;
    s = longint'($signed(w));
    u = longint'({32'b0, w});
    case (c)
      4'd0: v = s >>> 20;
      4'd1: v = (s >>> 25) * 32 + ((u >> 7) & 31);
      4'd2: v = (s >>> 31) * 4096 + ((u >> 7) & 1) * 2048
              + ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2;
      4'd3: v = (s >>> 31) * 1048576 + ((u >> 12) & 255) * 4096
              + ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2;
      4'd4: v = (s >>> 12) * 4096;
      4'd5: v = u >> 20;
      4'd6: v = x64 ? ((u >> 20) & 63) : ((u >> 20) & 31);
      4'd7: v = (u >> 15) & 31;
      default: v = 0;
    endcase
    if (!x64) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] c,
                       input logic [31:0] w, input logic [3:0] t);
    in_valid   = v;
    in_control = c;
    in_instr   = w;
    in_tag     = t;
    cur.x32    = model(w, c, 1'b0)[31:0];
    cur.x64    = model(w, c, 1'b1);
    cur.tag    = t;
    cur.err    = c[3];
  endtask

  task automatic step();
    bit acc, xfr;
    @(negedge clk);
    chk("in_ready32", 64'(r32), 64'(q.size() < 2));
    chk("in_ready64", 64'(r64), 64'(q.size() < 2));
    chk("out_valid32", 64'(v32), 64'(q.size() > 0));
    chk("out_valid64", 64'(v64), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("imm32", 64'(imm32), 64'(q[0].x32));
      chk("imm64", imm64, q[0].x64);
      chk("tag32", 64'(t32), 64'(q[0].tag));
      chk("tag64", 64'(t64), 64'(q[0].tag));
      chk("err32", 64'(e32), 64'(q[0].err));
      chk("err64", 64'(e64), 64'(q[0].err));
    end else if (zexp) begin
      chk("idle_imm32", 64'(imm32), 64'd0);
      chk("idle_imm64", imm64, 64'd0);
      chk("idle_tag", 64'({t32, t64}), 64'd0);
      chk("idle_err", 64'({e32, e64}), 64'd0);
    end
    acc = in_valid && (q.size() < 2);
    xfr = out_ready && (q.size() > 0);
    @(posedge clk);
    if (!rst_n || flush) begin
      q.delete();
      zexp = 1'b1;
    end else begin
      if (xfr) void'(q.pop_front());
      if (acc) begin
        q.push_back(cur);
        zexp = 1'b0;
      end
    end
    #1;
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{4'b0000, 32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    tbl[1]  = '{4'b0010, 32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    tbl[2]  = '{4'b0100, 32'h12345037, 32'h12345000, 64'h0000000012345000, 1'b0};
    tbl[3]  = '{4'b0101, 32'hFFF00093, 32'h00000FFF, 64'h0000000000000FFF, 1'b0};
    tbl[4]  = '{4'b0100, 32'h80000037, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    tbl[5]  = '{4'b0110, 32'h03F01013, 32'h0000001F, 64'h000000000000003F, 1'b0};
    tbl[6]  = '{4'b0111, 32'h000F8073, 32'h0000001F, 64'h000000000000001F, 1'b0};
    tbl[7]  = '{4'b1111, 32'hFFFFFFFF, 32'h00000000, 64'h0000000000000000, 1'b1};
    tbl[8]  = '{4'b0001, 32'hFE000FA3, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    tbl[9]  = '{4'b0011, 32'h8000006F, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0};
    tbl[10] = '{4'b1000, 32'h12345678, 32'h00000000, 64'h0000000000000000, 1'b1};
    tbl[11] = '{4'b0000, 32'h7FF00013, 32'h000007FF, 64'h00000000000007FF, 1'b0};

    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 4'd0, 32'hFFF00093, 4'd9);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    zexp = 1'b1;
    rst_n = 1'b1;
    drive(1'b0, 4'd0, 32'h0, 4'd0);
    step();

    // Back-to-back table stream, expectations from the hand-derived table.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, tbl[i].c, tbl[i].ins, 4'(i + 1));
      cur.x32 = tbl[i].x32;
      cur.x64 = tbl[i].x64;
      cur.err = tbl[i].err;
      step();
    end
    drive(1'b0, 4'd0, 32'h0, 4'd0);
    repeat (2) step();

    // Back-pressure: A to OUT, B to SKID, C held off until drain.
    out_ready = 1'b0;
    drive(1'b1, 4'd0, 32'h00100093, 4'hA);
    step();
    drive(1'b1, 4'd1, 32'h00000FA3, 4'hB);
    step();
    drive(1'b1, 4'd2, 32'h00000463, 4'hC);
    repeat (3) step();
    out_ready = 1'b1;
    repeat (2) step();
    drive(1'b0, 4'd0, 32'h0, 4'd0);
    repeat (3) step();

    // Flush while full with an input offered.
    out_ready = 1'b0;
    drive(1'b1, 4'd4, 32'hABCDE037, 4'h1);
    step();
    drive(1'b1, 4'd3, 32'h0040006F, 4'h2);
    step();
    drive(1'b1, 4'd0, 32'h12300013, 4'h3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 4'd0);
    out_ready = 1'b1;
    repeat (2) step();

    // Reset mid-stream while full.
    out_ready = 1'b0;
    drive(1'b1, 4'd7, 32'h000F8073, 4'h5);
    step();
    drive(1'b1, 4'd6, 32'h01F01013, 4'h6);
    repeat (2) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(1'b0, 4'd0, 32'h0, 4'd0);
    out_ready = 1'b1;
    repeat (2) step();

    // Randomised traffic with occasional flush.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 4) != 0, 4'($urandom_range(0, 15)),
            $urandom, 4'($urandom));
      out_ready = ($urandom % 3) != 0;
      flush = ($urandom % 50) == 0;
      step();
    end
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 4'd0, 32'h0, 4'd0);
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
